uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter CLK_DIV, default 234: clock cycles per UART bit (27 MHz / 115200 baud); legal range 2..65535.
REQ-002 Parameter FIFO_AW, default 4: FIFO address width; depth = 2**FIFO_AW entries.
REQ-003 clk  input  1  single system clock; all logic on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 tx_wdata  input  8  byte to transmit.
REQ-006 tx_wten  input  1  write strobe; one byte per cycle while high.
REQ-007 err_clr  input  1  synchronous clear of the sticky error flags.
REQ-008 tx_fifo_full  output  1  FIFO holds 2**FIFO_AW bytes.
REQ-009 tx_fifo_overrun  output  1  sticky: a write was attempted while full.
REQ-010 tx_fifo_underrun  output  1  sticky underrun flag; constant 0, since the serializer pops only when the FIFO is non-empty.
REQ-011 tx_busy  output  1  high whenever the serializer is not in IDLE.
REQ-012 tx_out  output  1  serial line, 8N1, idle high, registered.

Function
REQ-013 Push occurs on tx_wten & ~tx_fifo_full; the byte is readable on the next cycle.
REQ-014 tx_fifo_full is derived from the registered occupancy count; a write while full is dropped even if a pop occurs in the same cycle.
REQ-015 A dropped write sets tx_fifo_overrun on the next edge; the flag holds until err_clr or rst, and a set in the same cycle as err_clr wins.
REQ-016 A simultaneous push and pop leaves the count unchanged; the pointers wrap modulo 2**FIFO_AW.
REQ-017 The FSM has four states: IDLE, START, DATA, STOP.
REQ-018 In IDLE, tx_out is 1; when the FIFO is non-empty, the FSM pops, loads the shift register, clears the baud and bit counters, and enters START.
REQ-019 In START, tx_out is 0 for CLK_DIV cycles; the FSM then enters DATA.
REQ-020 In DATA, the FSM sends 8 bits LSB first, each for CLK_DIV cycles; after bit 7 it enters STOP.
REQ-021 In STOP, tx_out is 1 for CLK_DIV cycles; the FSM then returns to IDLE.
REQ-022 Back-to-back frames are separated by exactly one IDLE cycle of tx_out=1.
REQ-023 Latency: a write at cycle t into an empty FIFO with the FSM idle drives tx_out low from cycle t+2.
REQ-024 One frame occupies 10*CLK_DIV cycles, from the start-bit edge to the end of the stop bit.
REQ-025 The baud counter is ceil(log2(CLK_DIV)) bits and the bit counter is 3 bits; neither wraps outside its state.
REQ-026 tx_wten is honoured in every state; FIFO writes are independent of the serializer.

Reset
REQ-027 On rst, the pointers, count and both sticky flags clear to 0, the FSM enters IDLE, tx_out is 1, tx_busy is 0, and tx_fifo_full is 0.
REQ-028 rst mid-frame aborts the frame: tx_out is 1 from the next edge, and queued bytes are discarded.
REQ-029 A write coincident with rst is discarded.

Structure
REQ-030 The baud default constant (CLK_DIV_115200 = 234) and the FSM state encoding belong in the shared UART package, which is also used by the receive side.
REQ-031 The FIFO is a sub-module, uart_fifo, parameterised by FIFO_AW, with push/pop/data/count/full/empty ports; it is reusable on the receive side.

Verification (CLK_DIV=4, FIFO_AW=4)
REQ-032 Write 0x55 at cycle t with the FIFO empty -> tx_out=0 during cycles t+2..t+5, then the bit sequence 1,0,1,0,1,0,1,0 with 4 cycles per bit, then 1 for 4 cycles; tx_busy is high for 40 cycles.
REQ-033 Write 0xA5 and 0x3C on consecutive cycles -> two frames, exactly one idle-high cycle between the stop bit and the second start bit, data bits LSB first.
REQ-034 18 consecutive writes 0x00..0x11 from idle -> 17 accepted (the first is popped at t+1); tx_fifo_full is high after the 17th write; the 18th is dropped, tx_fifo_overrun=1 persists; err_clr pulse -> 0.
REQ-035 Assert rst during DATA bit 3 of 0xFF with 5 bytes queued -> tx_out=1 on the next edge, FSM in IDLE, FIFO empty, no further frames.
REQ-036 err_clr held high while writing to a full FIFO -> tx_fifo_overrun=1 (set wins); tx_fifo_underrun remains 0 throughout all scenarios.

Source files
------------

// File: rtl/uart_tx_pkg.sv
// Shared UART definitions, used by both the transmit and receive sides.
//   CLK_DIV_115200 : clock cycles per bit for 115200 baud from a 27 MHz clock
//   uart_state_t   : serializer / deserializer state encoding
package uart_tx_pkg;

  localparam int CLK_DIV_115200 = 234;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_t;

endpackage

// File: rtl/uart_tx_if.sv
// Host-side bundle of the UART transmitter.
//   master : host; drives tx_wdata, tx_wten, err_clr and watches status / line
//   slave  : uart_tx; receives writes and error clears, drives status and tx_out
interface uart_tx_if;
  logic [7:0] tx_wdata;
  logic       tx_wten;
  logic       err_clr;
  logic       tx_fifo_full;
  logic       tx_fifo_overrun;
  logic       tx_fifo_underrun;
  logic       tx_busy;
  logic       tx_out;

  modport master (
    output tx_wdata, tx_wten, err_clr,
    input  tx_fifo_full, tx_fifo_overrun, tx_fifo_underrun, tx_busy, tx_out
  );

  modport slave (
    input  tx_wdata, tx_wten, err_clr,
    output tx_fifo_full, tx_fifo_overrun, tx_fifo_underrun, tx_busy, tx_out
  );
endinterface

// File: rtl/uart_fifo.sv
// Byte FIFO shared by the UART transmit and receive paths.
//   clk, rst : system clock, synchronous active-high reset
//   push     : write request, ignored while full
//   wdata    : byte written on push
//   pop      : read request, ignored while empty
//   rdata    : head entry; a byte pushed on one edge is visible after that edge
//   count    : registered occupancy, 0 .. 2**FIFO_AW
//   full     : count == 2**FIFO_AW
//   empty    : count == 0
module uart_fifo #(
  parameter int FIFO_AW = 4,
  parameter int DW      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [DW-1:0]    wdata,
  input  logic             pop,
  output logic [DW-1:0]    rdata,
  output logic [FIFO_AW:0] count,
  output logic             full,
  output logic             empty
);
  localparam int DEPTH = 1 << FIFO_AW;

  logic [DW-1:0]      mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic               do_push;
  logic               do_pop;

  assign full    = (count == (FIFO_AW+1)'(DEPTH));
  assign empty   = (count == '0);
  // full comes from the registered count, so a write while full is dropped
  // even when a pop happens in the same cycle.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end
endmodule

// File: rtl/uart_tx.sv
// UART transmitter: byte FIFO feeding an 8N1 serializer.
//   clk, rst : system clock, synchronous active-high reset
//   bus      : uart_tx_if.slave
//     tx_wdata/tx_wten  : byte write, one per cycle while tx_wten is high
//     err_clr           : clears the sticky overrun flag (a new set wins)
//     tx_fifo_full      : FIFO holds 2**FIFO_AW bytes
//     tx_fifo_overrun   : sticky, a write hit a full FIFO
//     tx_fifo_underrun  : sticky, always 0 (pops only happen when non-empty)
//     tx_busy           : serializer is not idle
//     tx_out            : registered serial line, idle high
//
// state    | meaning
// ST_IDLE  | line high; pops the next byte as soon as the FIFO is non-empty
// ST_START | line low for CLK_DIV cycles
// ST_DATA  | 8 data bits LSB first, CLK_DIV cycles each
// ST_STOP  | line high for CLK_DIV cycles, then back to idle
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_115200,
  parameter int FIFO_AW = 4
) (
  input  logic     clk,
  input  logic     rst,
  uart_tx_if.slave bus
);
  localparam int                BAUD_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);

  uart_state_t       state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shreg_q, shreg_d;
  logic              tx_q, tx_d;
  logic              overrun_q;

  logic              fifo_pop;
  logic [7:0]        fifo_rdata;
  logic [FIFO_AW:0]  fifo_count;
  logic              fifo_full;
  logic              fifo_empty;
  logic              unused_fifo_count;

  uart_fifo #(
    .FIFO_AW (FIFO_AW),
    .DW      (8)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (bus.tx_wten),
    .wdata (bus.tx_wdata),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign unused_fifo_count = ^fifo_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
    end
  end

  // tx_d is the line level for the state being entered, so tx_out switches
  // on the same edge as the state register.
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shreg_d  = shreg_q;
    tx_d     = tx_q;
    fifo_pop = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shreg_d  = fifo_rdata;
          baud_d   = '0;
          bit_d    = '0;
          state_d  = ST_START;
          tx_d     = 1'b0;
        end
      end
      ST_START: begin
        if (baud_q == BAUD_LAST) begin
          baud_d  = '0;
          state_d = ST_DATA;
          tx_d    = shreg_q[0];
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (baud_q == BAUD_LAST) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = ST_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 1'b1;
            shreg_d = {1'b0, shreg_q[7:1]};
            tx_d    = shreg_q[1];
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      ST_STOP: begin
        tx_d = 1'b1;
        if (baud_q == BAUD_LAST) begin
          baud_d  = '0;
          state_d = ST_IDLE;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A new overrun in the same cycle as err_clr takes priority over the clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      overrun_q <= 1'b0;
    end else if (bus.tx_wten && fifo_full) begin
      overrun_q <= 1'b1;
    end else if (bus.err_clr) begin
      overrun_q <= 1'b0;
    end
  end

  assign bus.tx_fifo_full     = fifo_full;
  assign bus.tx_fifo_overrun  = overrun_q;
  assign bus.tx_fifo_underrun = 1'b0;
  assign bus.tx_busy          = (state_q != ST_IDLE);
  assign bus.tx_out           = tx_q;
endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx with CLK_DIV=4, FIFO_AW=4. Written bytes go into
// a scoreboard queue; a line monitor rebuilds each frame and compares it with
// the queue head.
module tb_uart_tx;
  localparam int CLK_DIV = 4;
  localparam int FRAME   = 10 * CLK_DIV;

  logic clk;
  logic rst;
  int   cyc = 0;
  int   n_assert = 0;
  int   n_fail = 0;
  int   frames_done = 0;
  logic [7:0] sb[$];
  int   start_q[$];

  uart_tx_if bus ();

  uart_tx #(
    .CLK_DIV (CLK_DIV),
    .FIFO_AW (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_frames(input int n, input int budget);
    for (int k = 0; k < budget && frames_done < n; k++) @(posedge clk);
    check("frames_done", 64'(frames_done), 64'(n));
  endtask

  task automatic wait_starts(input int n, input int budget);
    for (int k = 0; k < budget && start_q.size() < n; k++) @(posedge clk);
    check("frame_started", 64'(start_q.size()), 64'(n));
  endtask

  // Line monitor: samples on the falling edge, 40 samples per frame.
  initial begin : mon
    forever begin
      @(negedge clk);
      if (rst !== 1'b0 || bus.tx_out !== 1'b0) continue;
      begin
        logic [39:0] obs_line;
        logic [39:0] exp_line;
        logic [9:0]  exp_bits;
        logic [7:0]  exp_b;
        logic [7:0]  obs_b;
        int          busy_n;
        bit          aborted;
        start_q.push_back(cyc);
        obs_line = '0;
        busy_n   = 0;
        aborted  = 1'b0;
        for (int i = 0; i < FRAME; i++) begin
          if (i > 0) @(negedge clk);
          if (rst !== 1'b0) begin
            aborted = 1'b1;
            break;
          end
          obs_line[i] = bus.tx_out;
          if (bus.tx_busy === 1'b1) busy_n++;
        end
        if (!aborted) begin
          check("frame_expected", 64'(sb.size() > 0), 64'd1);
          if (sb.size() > 0) begin
            exp_b    = sb.pop_front();
            exp_bits = {1'b1, exp_b, 1'b0};
            for (int i = 0; i < FRAME; i++) exp_line[i] = exp_bits[i / CLK_DIV];
            for (int k = 0; k < 8; k++) obs_b[k] = obs_line[CLK_DIV * (k + 1) + CLK_DIV / 2];
            check("frame_byte", 64'(obs_b), 64'(exp_b));
            check("frame_line", 64'(obs_line), 64'(exp_line));
            check("busy_cycles", 64'(busy_n), 64'(FRAME));
          end
          frames_done++;
        end
      end
    end
  end

  initial begin : stim
    int w_cyc;
    int base;
    int s;

    rst          = 1'b1;
    bus.tx_wten  = 1'b1;
    bus.tx_wdata = 8'hEE;
    bus.err_clr  = 1'b0;

    // Reset with a coincident write, which must be discarded.
    repeat (3) @(posedge clk);
    #1;
    rst         = 1'b0;
    bus.tx_wten = 1'b0;
    @(negedge clk);
    check("rst_tx_out", 64'(bus.tx_out), 64'd1);
    check("rst_busy", 64'(bus.tx_busy), 64'd0);
    check("rst_full", 64'(bus.tx_fifo_full), 64'd0);
    check("rst_overrun", 64'(bus.tx_fifo_overrun), 64'd0);
    check("rst_underrun", 64'(bus.tx_fifo_underrun), 64'd0);
    repeat (20) @(posedge clk);
    check("no_frame_after_rst_write", 64'(start_q.size()), 64'd0);

    // Single byte 0x55: latency and full frame.
    @(posedge clk); #1;
    bus.tx_wten  = 1'b1;
    bus.tx_wdata = 8'h55;
    w_cyc        = cyc;
    sb.push_back(8'h55);
    @(posedge clk); #1;
    bus.tx_wten = 1'b0;
    wait_frames(1, 100);
    check("latency_55", 64'(start_q[0] - w_cyc), 64'd2);

    // Two back-to-back bytes: one idle cycle between frames.
    repeat (5) @(posedge clk);
    #1;
    bus.tx_wten  = 1'b1;
    bus.tx_wdata = 8'hA5;
    w_cyc        = cyc;
    sb.push_back(8'hA5);
    @(posedge clk); #1;
    bus.tx_wdata = 8'h3C;
    sb.push_back(8'h3C);
    @(posedge clk); #1;
    bus.tx_wten = 1'b0;
    wait_frames(3, 200);
    check("latency_a5", 64'(start_q[1] - w_cyc), 64'd2);
    check("frame_gap", 64'(start_q[2] - start_q[1]), 64'(FRAME + 1));

    // 18 writes from idle: first is popped immediately, 16 fill the FIFO,
    // the 18th is dropped.
    repeat (5) @(posedge clk);
    for (int i = 0; i < 18; i++) begin
      @(posedge clk); #1;
      if (i == 17) check("full_after_17", 64'(bus.tx_fifo_full), 64'd1);
      bus.tx_wten  = 1'b1;
      bus.tx_wdata = 8'(i);
      if (i < 17) sb.push_back(8'(i));
    end
    @(posedge clk); #1;
    bus.tx_wten = 1'b0;
    check("overrun_set", 64'(bus.tx_fifo_overrun), 64'd1);
    repeat (10) @(posedge clk);
    #1;
    check("overrun_sticky", 64'(bus.tx_fifo_overrun), 64'd1);
    bus.err_clr = 1'b1;
    @(posedge clk); #1;
    bus.err_clr = 1'b0;
    check("overrun_cleared", 64'(bus.tx_fifo_overrun), 64'd0);
    wait_frames(20, 17 * (FRAME + 1) + 100);
    check("sb_drained", 64'(sb.size()), 64'd0);

    // Fill again, then write into a full FIFO while err_clr is high.
    repeat (5) @(posedge clk);
    for (int i = 0; i < 17; i++) begin
      @(posedge clk); #1;
      bus.tx_wten  = 1'b1;
      bus.tx_wdata = 8'(8'h80 + i);
      sb.push_back(8'(8'h80 + i));
    end
    @(posedge clk); #1;
    check("full_again", 64'(bus.tx_fifo_full), 64'd1);
    bus.tx_wdata = 8'h99;
    bus.err_clr  = 1'b1;
    @(posedge clk); #1;
    bus.tx_wten = 1'b0;
    check("overrun_set_wins", 64'(bus.tx_fifo_overrun), 64'd1);
    @(posedge clk); #1;
    bus.err_clr = 1'b0;
    check("overrun_clr_held", 64'(bus.tx_fifo_overrun), 64'd0);
    check("underrun_zero", 64'(bus.tx_fifo_underrun), 64'd0);

    // Flush everything with a reset.
    rst = 1'b1;
    @(posedge clk); #1;
    sb.delete();
    rst = 1'b0;
    check("flush_full", 64'(bus.tx_fifo_full), 64'd0);
    repeat (5) @(posedge clk);

    // 0xFF plus 5 queued bytes; reset during data bit 3.
    base = start_q.size();
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      bus.tx_wten  = 1'b1;
      bus.tx_wdata = (i == 0) ? 8'hFF : 8'(i);
      sb.push_back(bus.tx_wdata);
    end
    @(posedge clk); #1;
    bus.tx_wten = 1'b0;
    wait_starts(base + 1, 20);
    s = start_q[start_q.size() - 1];
    for (int k = 0; k < 100 && cyc < s + CLK_DIV * 4 + 1; k++) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_tx_out", 64'(bus.tx_out), 64'd1);
    check("abort_busy", 64'(bus.tx_busy), 64'd0);
    check("abort_fifo_empty", 64'(dut.u_fifo.empty), 64'd1);
    check("abort_full", 64'(bus.tx_fifo_full), 64'd0);
    sb.delete();
    base = start_q.size();
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (300) @(posedge clk);
    #1;
    check("no_frames_after_abort", 64'(start_q.size()), 64'(base));
    check("line_idle_after_abort", 64'(bus.tx_out), 64'd1);
    check("underrun_final", 64'(bus.tx_fifo_underrun), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
